// File: rtl/bfu_pipe.sv
// Pipelined modular butterfly for the Dilithium NTT/INTT datapath.
// Each slot carries its own mode, so the mode can change on every cycle.
// The product comes from an external multiplier with a fixed latency.
// The item's a/b/mode ride a delay line so they line up with mul_result.
// Latency from in_valid to out_valid is MUL_LAT + 3 cycles.
module bfu_pipe #(
  parameter int DATA_W  = 23,
  parameter int PARAM_Q = 8380417,
  parameter int MUL_LAT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] omega,
  output logic              mul_valid,
  output logic [DATA_W-1:0] mul_opt1,
  output logic [DATA_W-1:0] mul_opt2,
  input  logic [DATA_W-1:0] mul_result,
  output logic              out_valid,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out
);

  localparam int HALF_Q = (PARAM_Q + 1) / 2;
  localparam int STAGES = MUL_LAT + 2;

  localparam logic [DATA_W:0]   Q_X     = (DATA_W+1)'(PARAM_Q);
  localparam logic [DATA_W-1:0] HALF_QW = DATA_W'(HALF_Q);

  localparam logic [1:0] M_NTT  = 2'd0;
  localparam logic [1:0] M_INTH = 2'd1;
  localparam logic [1:0] M_PWM  = 2'd2;
  localparam logic [1:0] M_INTT = 2'd3;

  // Per-item context carried alongside the multiplier.
  typedef struct packed {
    logic [1:0]        mode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } item_t;

  // Valid bits for each stage:
  //   [0]         is the mul_* stage.
  //   [MUL_LAT]   lines up with mul_result.
  //   [MUL_LAT+1] is stage 1.
  //   [STAGES]    is the output stage.
  logic [STAGES:0] vld_pipe;
  item_t           dly [MUL_LAT+1];

  logic [DATA_W-1:0] s1_s, s1_d, s1_m;
  logic [1:0]        s1_mode;

  // Modular add.
  // The sum is formed one bit wider, so a + b can never wrap.
  function automatic logic [DATA_W-1:0] add_mod(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y);
    logic [DATA_W:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    if (sum >= Q_X) sum = sum - Q_X;
    return sum[DATA_W-1:0];
  endfunction

  // Modular subtract.
  // A negative signed difference is folded back by adding q.
  function automatic logic [DATA_W-1:0] sub_mod(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y);
    logic signed [DATA_W:0] diff;
    diff = $signed({1'b0, x}) - $signed({1'b0, y});
    if (diff < 0) diff = diff + $signed(Q_X);
    return diff[DATA_W-1:0];
  endfunction

  // Multiply by 2^-1 mod q.
  // For an odd x, (x >> 1) + (q+1)/2 stays below q.
  function automatic logic [DATA_W-1:0] half_mod(input logic [DATA_W-1:0] x);
    return x[0] ? (x >> 1) + HALF_QW : (x >> 1);
  endfunction

  assign mul_valid = vld_pipe[0];
  assign out_valid = vld_pipe[STAGES];

  // Valid shift register. It advances unconditionally: there is no
  // backpressure, and an idle slot simply travels through as a bubble.
  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
  end

  // Stage 0: pick the multiplier operands by mode and capture the item.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_opt1 <= '0;
      mul_opt2 <= '0;
      dly[0]   <= '0;
    end else begin
      unique case (mode)
        M_NTT:   begin mul_opt1 <= b;             mul_opt2 <= omega; end
        M_PWM:   begin mul_opt1 <= a;             mul_opt2 <= b;     end
        default: begin mul_opt1 <= sub_mod(a, b); mul_opt2 <= omega; end
      endcase
      dly[0] <= '{mode: mode, a: a, b: b};
    end
  end

  // Delay line that keeps the item context aligned with mul_result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= MUL_LAT; k++) dly[k] <= '0;
    end else begin
      for (int k = 1; k <= MUL_LAT; k++) dly[k] <= dly[k-1];
    end
  end

  // Stage 1: form the sum and difference.
  // On a bubble slot the product is forced to 0, so garbage from the
  // multiplier never enters the datapath.
  logic [DATA_W-1:0] m_eff, y_sel;
  always_comb begin
    m_eff = vld_pipe[MUL_LAT] ? mul_result : '0;
    y_sel = (dly[MUL_LAT].mode == M_NTT) ? m_eff : dly[MUL_LAT].b;
  end

  // Stage 1 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_s    <= '0;
      s1_d    <= '0;
      s1_m    <= '0;
      s1_mode <= '0;
    end else begin
      s1_s    <= add_mod(dly[MUL_LAT].a, y_sel);
      s1_d    <= sub_mod(dly[MUL_LAT].a, m_eff);
      s1_m    <= m_eff;
      s1_mode <= dly[MUL_LAT].mode;
    end
  end

  // Stage 2: per-mode output selection, including the INTT halving.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
    end else begin
      unique case (s1_mode)
        M_NTT:  begin a_out <= s1_s;           b_out <= s1_d;           end
        M_INTH: begin a_out <= half_mod(s1_s); b_out <= half_mod(s1_m); end
        M_PWM:  begin a_out <= s1_m;           b_out <= '0;             end
        M_INTT: begin a_out <= s1_s;           b_out <= s1_m;           end
        default: begin a_out <= '0;            b_out <= '0;             end
      endcase
    end
  end

endmodule

// File: tb/tb_bfu_pipe.sv
// Bench for bfu_pipe.
// Two instances (MUL_LAT = 8 and MUL_LAT = 4) share one stimulus stream.
// Each instance has its own behavioural modular multiplier.
// Expected results enter per-instance queues when an item is sampled.
// They are popped when the item falls due, at a fixed latency of MUL_LAT + 3.
module tb_bfu_pipe;
  localparam int      W  = 23;
  localparam int      Q  = 8380417;
  localparam longint  QL = 64'd8380417;
  localparam int      L0 = 8;
  localparam int      L1 = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [1:0]   mode = '0;
  logic [W-1:0] a = '0, b = '0, omega = '0;

  logic         mv0, ov0, mv1, ov1;
  logic [W-1:0] mo1_0, mo2_0, mr0, ao0, bo0;
  logic [W-1:0] mo1_1, mo2_1, mr1, ao1, bo1;

  bfu_pipe #(.DATA_W(W), .PARAM_Q(Q), .MUL_LAT(L0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .a(a), .b(b), .omega(omega),
    .mul_valid(mv0), .mul_opt1(mo1_0), .mul_opt2(mo2_0), .mul_result(mr0),
    .out_valid(ov0), .a_out(ao0), .b_out(bo0));

  bfu_pipe #(.DATA_W(W), .PARAM_Q(Q), .MUL_LAT(L1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .a(a), .b(b), .omega(omega),
    .mul_valid(mv1), .mul_opt1(mo1_1), .mul_opt2(mo2_1), .mul_result(mr1),
    .out_valid(ov1), .a_out(ao1), .b_out(bo1));

  initial forever #5 clk = ~clk;

  function automatic logic [W-1:0] mulq(input logic [W-1:0] x, input logic [W-1:0] y);
    longint p;
    p = (longint'(x) * longint'(y)) % QL;
    return W'(p);
  endfunction

  // Behavioural multipliers with their respective latencies.
  logic [W-1:0] mp0 [L0];
  logic [W-1:0] mp1 [L1];
  always @(posedge clk) begin
    mp0[0] <= mv0 ? mulq(mo1_0, mo2_0) : '0;
    for (int k = 1; k < L0; k++) mp0[k] <= mp0[k-1];
    mp1[0] <= mv1 ? mulq(mo1_1, mo2_1) : '0;
    for (int k = 1; k < L1; k++) mp1[k] <= mp1[k-1];
  end
  assign mr0 = mp0[L0-1];
  assign mr1 = mp1[L1-1];

  // Reference butterfly.
  // Halving is done as multiplication by the inverse of 2 mod q.
  task automatic ref_bfu(input logic [1:0] md, input longint x, input longint y, input longint w,
                         output logic [W-1:0] ra, output logic [W-1:0] rb);
    longint m, hinv;
    hinv = (QL + 1) / 2;
    case (md)
      2'd0:    m = (y * w) % QL;
      2'd2:    m = (x * y) % QL;
      default: m = (((x - y + QL) % QL) * w) % QL;
    endcase
    case (md)
      2'd0:    begin ra = W'((x + m) % QL);                rb = W'((x - m + QL) % QL); end
      2'd1:    begin ra = W'((((x + y) % QL) * hinv) % QL); rb = W'((m * hinv) % QL);  end
      2'd2:    begin ra = W'(m);                           rb = '0;                    end
      default: begin ra = W'((x + y) % QL);                rb = W'(m);                 end
    endcase
  endtask

  typedef struct {
    int           due;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] a, b, w, o1, o2, ea, eb;
  } vec_t;

  function automatic vec_t mk(input int m, input int x, input int y, input int w,
                              input int o1, input int o2, input int ea, input int eb);
    vec_t v;
    v.mode = 2'(m);
    v.a    = W'(x);
    v.b    = W'(y);
    v.w    = W'(w);
    v.o1   = W'(o1);
    v.o2   = W'(o2);
    v.ea   = W'(ea);
    v.eb   = W'(eb);
    return v;
  endfunction

  // Stimulus-side expectation hand-off to the monitor.
  bit           exp_en = 1'b0, opt_en = 1'b0;
  logic [W-1:0] exp_a = '0, exp_b = '0, e_o1 = '0, e_o2 = '0;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Compares one instance's output slot against its scoreboard.
  task automatic mon_out(input int k, input logic ov, input logic [W-1:0] ao,
                         input logic [W-1:0] bo);
    exp_t e;
    bit   have;
    int   lat;
    have = 1'b0;
    e    = '{0, '0, '0};
    lat  = (k == 0) ? L0 : L1;
    if (k == 0) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1'b1; end
    end else begin
      if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1'b1; end
    end
    if (have || ov === 1'b1) begin
      n_vec++;
      if (ov !== have) begin
        n_err++;
        $display("FAIL out_valid lat%0d cyc %0d: got %b want %b", lat, cyc, ov, have);
      end else if (ao !== e.ea || bo !== e.eb) begin
        n_err++;
        $display("FAIL out_data lat%0d cyc %0d: got a=%0d b=%0d want a=%0d b=%0d",
                 lat, cyc, ao, bo, e.ea, e.eb);
      end
    end
  endtask

  bit           opt_q = 1'b0, rst_q = 1'b0;
  logic [W-1:0] eo1_q = '0, eo2_q = '0;

  // Monitor: runs at the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    mon_out(0, ov0, ao0, bo0);
    mon_out(1, ov1, ao1, bo1);
    if (opt_q) begin
      n_vec++;
      if ({mv0, mo1_0, mo2_0} !== {1'b1, eo1_q, eo2_q}) begin
        n_err++;
        $display("FAIL mul_ops lat8: got v=%b o1=%0d o2=%0d want v=1 o1=%0d o2=%0d",
                 mv0, mo1_0, mo2_0, eo1_q, eo2_q);
      end
      n_vec++;
      if ({mv1, mo1_1, mo2_1} !== {1'b1, eo1_q, eo2_q}) begin
        n_err++;
        $display("FAIL mul_ops lat4: got v=%b o1=%0d o2=%0d want v=1 o1=%0d o2=%0d",
                 mv1, mo1_1, mo2_1, eo1_q, eo2_q);
      end
    end
    if (rst_q) begin
      n_vec++;
      if ({mv0, mo1_0, mo2_0, ov0, ao0, bo0} !== '0) begin
        n_err++;
        $display("FAIL reset_zero lat8: got %h want 0", {mv0, mo1_0, mo2_0, ov0, ao0, bo0});
      end
      n_vec++;
      if ({mv1, mo1_1, mo2_1, ov1, ao1, bo1} !== '0) begin
        n_err++;
        $display("FAIL reset_zero lat4: got %h want 0", {mv1, mo1_1, mo2_1, ov1, ao1, bo1});
      end
    end
    // Whatever is applied now is sampled at edge cyc+1.
    // Its result then appears MUL_LAT+2 edges later.
    if (rst) begin
      q0.delete();
      q1.delete();
    end else if (in_valid && exp_en) begin
      q0.push_back('{cyc + 1 + L0 + 2, exp_a, exp_b});
      q1.push_back('{cyc + 1 + L1 + 2, exp_a, exp_b});
    end
    opt_q = opt_en && in_valid && !rst;
    eo1_q = e_o1;
    eo2_q = e_o2;
    rst_q = rst;
  end

  task automatic drive(input logic [1:0] md, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] w, input logic [W-1:0] ea, input logic [W-1:0] eb,
                       input bit oen, input logic [W-1:0] o1, input logic [W-1:0] o2);
    mode = md; a = x; b = y; omega = w;
    exp_a = ea; exp_b = eb; e_o1 = o1; e_o2 = o2;
    in_valid = 1'b1; exp_en = 1'b1; opt_en = oen;
    @(posedge clk); #1;
    in_valid = 1'b0; exp_en = 1'b0; opt_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_rand();
    logic [1:0]   md;
    logic [W-1:0] x, y, w, ra, rb;
    md = 2'($urandom_range(0, 3));
    x  = W'($urandom_range(0, Q - 1));
    y  = W'($urandom_range(0, Q - 1));
    w  = W'($urandom_range(0, Q - 1));
    ref_bfu(md, longint'(x), longint'(y), longint'(w), ra, rb);
    drive(md, x, y, w, ra, rb, 1'b0, '0, '0);
  endtask

  vec_t vt[10];

  initial begin
    // Directed vectors: mode, a, b, omega, opt1, opt2, a_out, b_out.
    vt[0] = mk(0, 1, 2, 3, 2, 3, 7, 8380412);
    vt[1] = mk(0, 8380416, 1, 1, 1, 1, 0, 8380415);
    vt[2] = mk(0, 0, 0, 5, 0, 5, 0, 0);
    vt[3] = mk(1, 3, 0, 1, 3, 1, 4190210, 4190210);
    vt[4] = mk(3, 3, 0, 1, 3, 1, 3, 3);
    vt[5] = mk(1, 0, 1, 1, 8380416, 1, 4190209, 4190208);
    vt[6] = mk(2, 5, 7, 9, 5, 7, 35, 0);
    vt[7] = mk(0, 0, 8380416, 8380416, 8380416, 8380416, 1, 8380416);
    vt[8] = mk(3, 8380416, 8380416, 2, 0, 2, 8380415, 0);
    vt[9] = mk(1, 8380416, 2, 1, 8380414, 1, 4190209, 4190207);

    // Power-on reset: the monitor checks the all-zero state after it.
    rst = 1'b1;
    idle(3);
    rst = 1'b0;

    // Directed vectors, issued back to back (the mode changes every cycle).
    foreach (vt[i])
      drive(vt[i].mode, vt[i].a, vt[i].b, vt[i].w, vt[i].ea, vt[i].eb,
            1'b1, vt[i].o1, vt[i].o2);
    idle(20);

    // Random stream with random bubbles.
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      drive_rand();
    end
    idle(20);

    // Reset with 6 items in flight.
    // in_valid is held high during the reset cycle to show it is ignored.
    // None of the 6 items may ever emerge.
    for (int i = 0; i < 6; i++) drive_rand();
    mode = 2'd2; a = 23'd9; b = 23'd9; omega = 23'd1;
    in_valid = 1'b1; exp_en = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; exp_en = 1'b0;
    drive(2'd0, 23'd1, 23'd2, 23'd3, 23'd7, 23'd8380412, 1'b1, 23'd2, 23'd3);
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
